// File: rtl/mux_sched_pkg.sv
// Shared types and defaults for the two-lane byte scheduler.
// Strict lane-0 priority is selected by MUX_SCHED_STRICT_PRIO_EN.
package mux_sched_pkg;

  localparam int DW_DEF        = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int MAX_BURST_DEF = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1
  } state_e;

  function automatic state_e serve_of(
    input logic lane
  );
    return lane ? SERVE1 : SERVE0;
  endfunction

endpackage

// File: rtl/mux_sched_2x1_fifo.sv
// Per-lane synchronous FIFO; a push while full is accepted
// only when the same cycle also pops.
module sched_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mux_sched_2x1.sv
// Round-robin 2:1 byte scheduler with burst limit and lane FIFOs.
// Define MUX_SCHED_STRICT_PRIO_EN for strict lane-0 priority.
module mux_sched_2x1
  import mux_sched_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dataIn0,
  input  logic          validIn0,
  input  logic [DW-1:0] dataIn1,
  input  logic          validIn1,
  output logic          pause0,
  output logic          pause1,
  output logic [DW-1:0] dataOut,
  output logic          validOut,
  output logic          selector,
  output logic          overflow0,
  output logic          overflow1
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] rdata0, rdata1;
  logic          empty0, empty1;
  logic          full0, full1;
  logic [CW-1:0] cnt0, cnt1;
  logic          rd0, rd1;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [3:0]    burst_q, burst_d;
  logic          gnt_vld;
  logic          gnt_lane;

  logic [DW-1:0] data_q;
  logic          valid_q, sel_q;
  logic          pause0_q, pause1_q;
  logic          ovf0_q, ovf1_q;

  sched_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (validIn0),
    .wdata_i (dataIn0),
    .pop_i   (rd0),
    .rdata_o (rdata0),
    .empty_o (empty0),
    .full_o  (full0),
    .count_o (cnt0)
  );

  sched_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (validIn1),
    .wdata_i (dataIn1),
    .pop_i   (rd1),
    .rdata_o (rdata1),
    .empty_o (empty1),
    .full_o  (full1),
    .count_o (cnt1)
  );

  logic ne0, ne1;
  assign ne0 = !empty0;
  assign ne1 = !empty1;

`ifdef MUX_SCHED_STRICT_PRIO_EN
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_lane = LANE0;
    state_d  = IDLE;
    last_d   = last_q;
    burst_d  = 4'd0;
    if (ne0) begin
      gnt_vld  = 1'b1;
      gnt_lane = LANE0;
    end else if (ne1) begin
      gnt_vld  = 1'b1;
      gnt_lane = LANE1;
    end
    if (gnt_vld) begin
      state_d = serve_of(gnt_lane);
      last_d  = gnt_lane;
      burst_d = 4'd1;
    end
  end
`else
  logic cur, ne_cur, ne_oth;
  assign cur    = (state_q == SERVE1);
  assign ne_cur = cur ? ne1 : ne0;
  assign ne_oth = cur ? ne0 : ne1;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_lane = LANE0;
    state_d  = state_q;
    last_d   = last_q;
    burst_d  = burst_q;
    unique case (state_q)
      IDLE: begin
        burst_d = 4'd1;
        if (ne0 && ne1) begin
          gnt_vld  = 1'b1;
          gnt_lane = ~last_q;
        end else if (ne0 || ne1) begin
          gnt_vld  = 1'b1;
          gnt_lane = ne1;
        end else begin
          burst_d = burst_q;
        end
      end
      SERVE0, SERVE1: begin
        if (ne_cur && burst_q < 4'(MAX_BURST)) begin
          gnt_vld  = 1'b1;
          gnt_lane = cur;
          burst_d  = burst_q + 4'd1;
        end else if (ne_oth) begin
          gnt_vld  = 1'b1;
          gnt_lane = ~cur;
          burst_d  = 4'd1;
        end else if (ne_cur) begin
          gnt_vld  = 1'b1;
          gnt_lane = cur;
          burst_d  = 4'd1;
        end else begin
          state_d  = IDLE;
          burst_d  = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (gnt_vld) begin
      state_d = serve_of(gnt_lane);
      last_d  = gnt_lane;
    end
  end
`endif

  assign rd0 = gnt_vld && (gnt_lane == LANE0);
  assign rd1 = gnt_vld && (gnt_lane == LANE1);

  // Occupancy after this edge drives next cycle's pause.
  logic          acc0, acc1;
  logic [CW-1:0] nx0, nx1;
  assign acc0 = validIn0 && (!full0 || rd0);
  assign acc1 = validIn1 && (!full1 || rd1);
  assign nx0  = cnt0 + CW'(acc0) - CW'(rd0);
  assign nx1  = cnt1 + CW'(acc1) - CW'(rd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= LANE1;
      burst_q  <= 4'd0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      pause0_q <= 1'b0;
      pause1_q <= 1'b0;
      ovf0_q   <= 1'b0;
      ovf1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      valid_q  <= gnt_vld;
      if (gnt_vld) begin
        data_q <= gnt_lane ? rdata1 : rdata0;
        sel_q  <= gnt_lane;
      end
      pause0_q <= (nx0 >= CW'(DEPTH - 1));
      pause1_q <= (nx1 >= CW'(DEPTH - 1));
      ovf0_q   <= ovf0_q | (validIn0 && !acc0);
      ovf1_q   <= ovf1_q | (validIn1 && !acc1);
    end
  end

  assign dataOut   = data_q;
  assign validOut  = valid_q;
  assign selector  = sel_q;
  assign pause0    = pause0_q;
  assign pause1    = pause1_q;
  assign overflow0 = ovf0_q;
  assign overflow1 = ovf1_q;

endmodule
